// File: rtl/reg_dump_reader_if.sv
// Bundle shared by the register dump reader and its environment: the dump
// request, the register-file read port, the beat stream and the status flags.
interface reg_dump_reader_if #(
  parameter int pw = 4
);
  logic          start;
  logic [pw-1:0] first_addr;
  logic [pw-1:0] last_addr;
  logic [pw-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [pw-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  // master is the reader itself; slave is the register file plus consumer side
  modport master (
    input  start, first_addr, last_addr, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_addr, out_last, busy, done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a contiguous (possibly wrapping) register range, capturing one
// register per READ cycle and streaming it out as a valid/ready beat.
module reg_dump_reader #(
  parameter int pw = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  reg_dump_reader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_reg;
  logic [pw-1:0] ptr_reg;
  logic [pw-1:0] end_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      end_reg       <= '0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ptr_reg     <= bus.first_addr;
            end_reg     <= bus.last_addr;
            // rd_addr is registered, so it is loaded one edge ahead of READ
            bus.rd_addr <= bus.first_addr;
            bus.busy    <= 1'b1;
            state_reg   <= READ;
          end
        end
        READ: begin
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= ptr_reg;
          bus.out_last  <= (ptr_reg == end_reg);
          bus.out_valid <= 1'b1;
          state_reg     <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.out_last) begin
              bus.done  <= 1'b1;
              state_reg <= DONE;
            end else begin
              ptr_reg     <= ptr_reg + 1'b1;
              bus.rd_addr <= ptr_reg + 1'b1;
              state_reg   <= READ;
            end
          end
        end
        DONE: begin
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench: a register-file array plus a range model
// predicts every beat, its order, the last flag and the done timing.
module tb_reg_dump_reader;

  localparam int PW   = 4;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if #(.pw(PW)) bus ();

  reg_dump_reader #(.pw(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  logic [7:0] regs [NREG];
  assign bus.rd_data = regs[bus.rd_addr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // 0: ready tied high, 1: random ready, 2: ready follows ready_manual
  int   ready_mode = 0;
  logic ready_manual = 1'b1;
  always @(posedge clk) begin
    #2;
    if (ready_mode == 2)      bus.out_ready = ready_manual;
    else if (ready_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    else                      bus.out_ready = 1'b1;
  end

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t got[$];
  int    done_cyc[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid && bus.out_ready)
        got.push_back('{bus.out_addr, bus.out_data, bus.out_last});
      if (bus.done)
        done_cyc.push_back(cyc);
    end
  end

  task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
    got.delete();
    done_cyc.delete();
    @(posedge clk); #1;
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic check_beats(input string name, input logic [3:0] f, input logic [3:0] l);
    int n;
    n = ((int'(l) - int'(f)) % NREG + NREG) % NREG + 1;
    vectors++;
    if (got.size() !== n) begin
      miscompares++;
      $display("FAIL %s beat_count got=%0d exp=%0d", name, got.size(), n);
    end
    for (int i = 0; i < got.size() && i < n; i++) begin
      logic [3:0] ea;
      logic       el;
      ea = 4'((int'(f) + i) % NREG);
      el = (i == n - 1);
      vectors++;
      if (got[i].addr !== ea || got[i].data !== regs[ea] || got[i].last !== el) begin
        miscompares++;
        $display("FAIL %s beat%0d got addr=%0d data=%h last=%b exp addr=%0d data=%h last=%b",
                 name, i, got[i].addr, got[i].data, got[i].last, ea, regs[ea], el);
      end else begin
        $display("%s beat%0d addr=%0d data=%h last=%b", name, i, got[i].addr, got[i].data, got[i].last);
      end
    end
  endtask

  task automatic finish_dump(input string name, input logic [3:0] f, input logic [3:0] l,
                             input int budget, input bit check_timing);
    int  n_cyc;
    int  busy_bad;
    bit  seen;
    int  n;
    n_cyc = 0; busy_bad = 0; seen = 1'b0;
    n = ((int'(l) - int'(f)) % NREG + NREG) % NREG + 1;
    while (!seen && n_cyc < budget) begin
      @(negedge clk);
      n_cyc++;
      if (!bus.busy) busy_bad++;
      if (bus.done) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done_timeout got=none exp=pulse within %0d cycles", name, budget);
    end
    vectors++;
    if (busy_bad != 0) begin
      miscompares++;
      $display("FAIL %s busy_low got=%0d cycles exp=0", name, busy_bad);
    end
    if (seen) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== l) begin
        miscompares++;
        $display("FAIL %s idle_after_done got busy=%b done=%b rd_addr=%0d exp busy=0 done=0 rd_addr=%0d",
                 name, bus.busy, bus.done, bus.rd_addr, l);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    check_beats(name, f, l);
    vectors++;
    if (done_cyc.size() != 1) begin
      miscompares++;
      $display("FAIL %s done_count got=%0d exp=1", name, done_cyc.size());
    end
    // done is high during cycle 2N+1, i.e. right after the 2N-th edge past the start edge
    if (check_timing && done_cyc.size() > 0) begin
      vectors++;
      if (done_cyc[0] - start_cyc != 2 * n) begin
        miscompares++;
        $display("FAIL %s done_latency got=%0d exp=%0d", name, done_cyc[0] - start_cyc, 2 * n);
      end
    end
    $display("%s dump first=%0d last=%0d beats=%0d", name, f, l, got.size());
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.rd_addr !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_addr !== 4'd0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got rd=%0d v=%b d=%h a=%0d l=%b busy=%b done=%b exp all zero",
               bus.rd_addr, bus.out_valid, bus.out_data, bus.out_addr, bus.out_last, bus.busy, bus.done);
    end
    reset_n = 1'b1;
    $display("reset applied");
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < NREG; i++) regs[i] = 8'h10 + 8'(i);
    ready_mode = 0;
    start_dump(4'd0, 4'd15);
    finish_dump("full", 4'd0, 4'd15, 200, 1'b1);
  endtask

  task automatic test_single();
    regs[7] = 8'hA5;
    ready_mode = 0;
    start_dump(4'd7, 4'd7);
    finish_dump("single", 4'd7, 4'd7, 50, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
    ready_mode = 0;
    start_dump(4'd14, 4'd1);
    finish_dump("wrap", 4'd14, 4'd1, 50, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [3:0] a0;
    logic [7:0] d0;
    int unstable;
    unstable = 0;
    ready_manual = 1'b0;
    ready_mode   = 2;
    start_dump(4'd2, 4'd3);
    @(posedge clk); #1;
    a0 = bus.out_addr;
    d0 = bus.out_data;
    vectors++;
    if (bus.out_valid !== 1'b1 || a0 !== 4'd2) begin
      miscompares++;
      $display("FAIL bp_first_beat got valid=%b addr=%0d exp valid=1 addr=2", bus.out_valid, a0);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_addr !== a0 || bus.out_data !== d0) unstable++;
    end
    vectors++;
    if (unstable != 0 || got.size() != 0) begin
      miscompares++;
      $display("FAIL bp_hold got unstable=%0d transfers=%0d exp 0 and 0", unstable, got.size());
    end
    ready_manual = 1'b1;
    finish_dump("backpressure", 4'd2, 4'd3, 50, 1'b0);
    ready_mode = 0;
  endtask

  task automatic test_coherency();
    int n;
    n = 0;
    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
    regs[5] = 8'h00;
    ready_mode = 0;
    start_dump(4'd0, 4'd7);
    while (bus.rd_addr !== 4'd2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (bus.rd_addr !== 4'd2) begin
      miscompares++;
      $display("FAIL coh_reach_reg2 got rd_addr=%0d exp=2", bus.rd_addr);
    end
    regs[5] = 8'h3C;
    bus.first_addr = 4'd9;
    bus.last_addr  = 4'd9;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_dump("coherency", 4'd0, 4'd7, 100, 1'b1);
    vectors++;
    if (got.size() < 6 || got[5].data !== 8'h3C) begin
      miscompares++;
      $display("FAIL coh_reg5 got=%h exp=3c", (got.size() < 6) ? 8'hxx : got[5].data);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    n = 0; found = 1'b0;
    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
    ready_mode = 0;
    start_dump(4'd0, 4'd7);
    while (!found && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.out_valid && bus.out_addr == 4'd2) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rst_mid_reach got=no third beat exp=third beat in SEND");
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_mid_state got v=%b busy=%b done=%b rd=%0d exp 0 0 0 0",
               bus.out_valid, bus.busy, bus.done, bus.rd_addr);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (got.size() != 2 || done_cyc.size() != 0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_abort got beats=%0d dones=%0d valid=%b exp 2 0 0",
               got.size(), done_cyc.size(), bus.out_valid);
    end
    $display("reset mid-dump after %0d beats", got.size());
    start_dump(4'd3, 4'd5);
    finish_dump("after_reset", 4'd3, 4'd5, 50, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [3:0] f;
      logic [3:0] l;
      for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
      f = 4'($urandom_range(0, NREG - 1));
      l = 4'($urandom_range(0, NREG - 1));
      ready_mode = 1;
      start_dump(f, l);
      finish_dump("random", f, l, 600, 1'b0);
    end
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = 8'h00;
    test_reset();
    test_full_dump();
    test_single();
    test_wrap();
    test_backpressure();
    test_coherency();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
